bsg_parity_checker: RTL
=======================

BSG_PARITY_CHECKER -- requirements
Module: bsg_parity_checker

Interface
REQ-001 SHALL have parameter: width_p, 128, data word width in bits (multiple of seg_width_p, >= 2).
REQ-002 SHALL have parameter: seg_width_p, 32, segment width for the first-stage partial XOR reduction.
REQ-003 SHALL have parameter: odd_p, 0, parity sense: 0 = even parity, 1 = odd parity.
REQ-004 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: v_i  input  1  upstream word valid.
REQ-007 SHALL have port: data_i  input  width_p  upstream data word.
REQ-008 SHALL have port: parity_i  input  1  parity bit transmitted with data_i.
REQ-009 SHALL have port: ready_o  output  1  block accepts the word this cycle when v_i & ready_o.
REQ-010 SHALL have port: v_o  output  1  checked word valid.
REQ-011 SHALL have port: data_o  output  width_p  checked data word, unmodified.
REQ-012 SHALL have port: err_o  output  1  parity mismatch for the word on data_o, qualified by v_o.
REQ-013 SHALL have port: yumi_i  input  1  downstream consumes data_o this cycle; asserted only when v_o = 1.
REQ-014 SHALL have port: clr_i  input  1  clears sticky error state.
REQ-015 SHALL have port: err_sticky_o  output  1  set by any consumed word with err_o = 1.
REQ-016 SHALL have port: err_cnt_o  output  16  count of consumed erroneous words (present only under REQ-031).

Function
REQ-017 SHALL use a two-stage pipeline: S1 registers data, parity_i and width_p/seg_width_p segment XORs; S2 folds the partials, XORs in parity_i, and registers data_o/err_o.
REQ-018 SHALL set err_o = (^data ^ parity) != odd_p for the word held in S2.
REQ-019 SHALL have a latency of exactly 2 cycles from acceptance to v_o when the pipeline is empty and yumi_i is high.
REQ-020 SHALL sustain one word per cycle while yumi_i is held high.
REQ-021 SHALL advance S2 when S2 is empty or yumi_i = 1; SHALL advance S1 into S2 only under that condition.
REQ-022 SHALL drive ready_o = !S1.v | S2-advance (bubble-collapsing); ready_o SHALL NOT depend on v_i.
REQ-023 SHALL hold data_o, err_o and v_o stable while v_o = 1 and yumi_i = 0.
REQ-024 SHALL contain at most 2 words; with S1 and S2 full and yumi_i = 0, ready_o = 0 and no data SHALL be lost or duplicated.
REQ-025 SHALL set err_sticky_o the cycle after a consume (v_o & yumi_i) with err_o = 1; SHALL clear it the cycle after clr_i = 1.
REQ-026 SHALL give set priority over clear when clr_i and an erroneous consume coincide (err_sticky_o = 1 next cycle).
REQ-027 SHALL update sticky/count state only on consume, never on a stalled erroneous word.

Reset
REQ-028 SHALL, on reset_i = 1 at a clock edge, clear both stage valids, err_sticky_o and err_cnt_o; v_o = 0, ready_o = 1 on the following cycle.
REQ-029 SHALL discard in-flight words when reset_i is asserted mid-operation; data registers need not be reset.
REQ-030 SHALL ignore v_i, yumi_i and clr_i while reset_i = 1.

Configuration
REQ-031 SHALL, with macro BSG_PARITY_CHECKER_ERR_CNT_EN defined, implement err_cnt_o: +1 per erroneous consume, saturating at 16'hFFFF; clr_i with a coincident erroneous consume yields 1.
REQ-032 SHALL, without BSG_PARITY_CHECKER_ERR_CNT_EN, omit the counter register and err_cnt_o port entirely; all other behaviour unchanged.

Structure
REQ-033 SHALL place the err_cnt width constant (16) and the S1 stage struct typedef (valid, data, parity, partials) in package bsg_parity_checker_pkg.
REQ-034 SHALL instantiate width_p/seg_width_p copies of one sub-module, bsg_parity_checker_seg, a combinational seg_width_p-bit XOR reduction.
REQ-035 SHALL assert (simulation only) width_p % seg_width_p == 0 and yumi_i -> v_o.

Verification
REQ-036 SHALL cover: reset, then data_i = 128'h1, parity_i = 1, odd_p = 0, yumi_i = 1 -> v_o = 1 two cycles later, err_o = 0.
REQ-037 SHALL cover: data_i = 128'h3, parity_i = 1 -> err_o = 1, err_sticky_o = 1 and err_cnt_o = 1 one cycle after consume.
REQ-038 SHALL cover: 3 back-to-back words with yumi_i = 0 -> ready_o = 0 after 2 accepted; releasing yumi_i delivers all 3 in order, no drops.
REQ-039 SHALL cover: clr_i = 1 in the same cycle as an erroneous consume with err_cnt_o = 5 -> err_sticky_o = 1, err_cnt_o = 1.
REQ-040 SHALL cover: err_cnt_o = 16'hFFFF plus one erroneous consume -> err_cnt_o stays 16'hFFFF.
REQ-041 SHALL cover: reset_i pulsed with both stages full -> v_o = 0, ready_o = 1, err_cnt_o = 0 next cycle; no stale word emerges.

Source files
------------

// File: rtl/bsg_parity_checker_pkg.sv
// Shared constants and the S1 stage payload for the pipelined parity checker.
package bsg_parity_checker_pkg;

   localparam int unsigned err_cnt_width_lp = 16;
   localparam int unsigned data_width_lp    = 128;
   localparam int unsigned seg_width_lp     = 32;
   localparam int unsigned num_segs_lp      = data_width_lp / seg_width_lp;

   // First pipeline stage: captured word plus its per-segment XOR partials
   typedef struct packed {
      logic                     v;
      logic [data_width_lp-1:0] data;
      logic                     parity;
      logic [num_segs_lp-1:0]   partials;
   } s1_s;

endpackage

// File: rtl/bsg_parity_checker_seg.sv
// Combinational XOR reduction of one data segment.
module bsg_parity_checker_seg #(
   parameter int unsigned seg_width_p = 32
) (
   input  logic [seg_width_p-1:0] data_i,
   output logic                   parity_o
);

   assign parity_o = ^data_i;

endmodule

// File: rtl/bsg_parity_checker.sv
// Two-stage pipelined parity checker with valid/ready input, valid/yumi output
// and sticky error tracking. Optional error counter: BSG_PARITY_CHECKER_ERR_CNT_EN.
// The S1 payload type lives in the package, so width_p/seg_width_p must match
// the package widths.
module bsg_parity_checker
   import bsg_parity_checker_pkg::*;
#(
   parameter int unsigned width_p     = data_width_lp,
   parameter int unsigned seg_width_p = seg_width_lp,
   parameter bit          odd_p       = 1'b0
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        v_i,
   input  logic [width_p-1:0]          data_i,
   input  logic                        parity_i,
   output logic                        ready_o,
   output logic                        v_o,
   output logic [width_p-1:0]          data_o,
   output logic                        err_o,
   input  logic                        yumi_i,
   input  logic                        clr_i,
   output logic                        err_sticky_o
`ifdef BSG_PARITY_CHECKER_ERR_CNT_EN
  ,output logic [err_cnt_width_lp-1:0] err_cnt_o
`endif
);

   localparam int unsigned segs_lp = width_p / seg_width_p;

   logic [segs_lp-1:0] seg_par;
   s1_s                s1_q, s1_d;
   logic               s2_v_q, s2_v_d;
   logic [width_p-1:0] s2_data_q, s2_data_d;
   logic               s2_err_q, s2_err_d;
   logic               sticky_q, sticky_d;
   logic               s2_adv, accept, consume, cons_err;

   // First-stage partial reductions, one per segment
   for (genvar g = 0; g < int'(segs_lp); g++) begin : g_seg
      bsg_parity_checker_seg #(.seg_width_p(seg_width_p)) u_seg (
         .data_i   (data_i[g*seg_width_p +: seg_width_p]),
         .parity_o (seg_par[g])
      );
   end

   // Handshake: S2 moves when empty or consumed; S1 frees up whenever S2 moves
   assign s2_adv   = !s2_v_q | yumi_i;
   assign ready_o  = !s1_q.v | s2_adv;
   assign accept   = v_i & ready_o;
   assign consume  = s2_v_q & yumi_i;
   assign cons_err = consume & s2_err_q;

   // Next-state for both pipeline stages
   always_comb begin
      s1_d      = s1_q;
      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      s2_err_d  = s2_err_q;
      if (accept) begin
         s1_d.v        = 1'b1;
         s1_d.data     = data_i;
         s1_d.parity   = parity_i;
         s1_d.partials = seg_par;
      end else if (s2_adv) begin
         s1_d.v = 1'b0;
      end
      if (s2_adv) begin
         s2_v_d    = s1_q.v;
         s2_data_d = s1_q.data;
         s2_err_d  = (^s1_q.partials) ^ s1_q.parity ^ odd_p;
      end
   end

   // Pipeline registers; only valids are reset, payload just follows
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_q.v <= 1'b0;
         s2_v_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_v_q <= s2_v_d;
      end
      s2_data_q <= s2_data_d;
      s2_err_q  <= s2_err_d;
   end

   // Sticky error: an erroneous consume wins over a coincident clear
   always_comb begin
      sticky_d = sticky_q;
      if (cons_err)   sticky_d = 1'b1;
      else if (clr_i) sticky_d = 1'b0;
   end

   // Sticky error register
   always_ff @(posedge clk_i) begin
      if (reset_i) sticky_q <= 1'b0;
      else         sticky_q <= sticky_d;
   end

   assign v_o          = s2_v_q;
   assign data_o       = s2_data_q;
   assign err_o        = s2_err_q;
   assign err_sticky_o = sticky_q;

`ifdef BSG_PARITY_CHECKER_ERR_CNT_EN
   logic [err_cnt_width_lp-1:0] cnt_q, cnt_d;

   // Saturating error counter; clear with a coincident error restarts at one
   always_comb begin
      cnt_d = cnt_q;
      if (cons_err) begin
         if (clr_i)               cnt_d = err_cnt_width_lp'(1);
         else if (cnt_q != '1)    cnt_d = cnt_q + err_cnt_width_lp'(1);
      end else if (clr_i) begin
         cnt_d = '0;
      end
   end

   // Error counter register
   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign err_cnt_o = cnt_q;
`endif

`ifndef SYNTHESIS
   // Configuration and downstream protocol sanity checks
   a_seg_div: assert property (@(posedge clk_i) (width_p % seg_width_p) == 0);
   a_pkg_w:   assert property (@(posedge clk_i)
                 (width_p == data_width_lp) && (seg_width_p == seg_width_lp));
   a_yumi_v:  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
`endif

endmodule
